// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI responder. It services link register reads and writes, accepts transmit
// packets (including chirp), and reports line-state changes to the link as RX CMDs.
module ulpi_phy_responder #(
   parameter logic [7:0] FUN_CTRL_RST = 8'h41,
   parameter logic [7:0] OTG_CTRL_RST = 8'h06
) (
   input  logic        CLK_60M,
   input  logic        RST_A_USB,
   input  logic        USB_RESETN,
   input  logic [7:0]  USB_DATA_I,
   output logic [7:0]  USB_DATA_O,
   output logic        USB_DATA_OE,
   output logic        USB_DIR,
   output logic        USB_NXT,
   input  logic        USB_STP,
   input  logic [1:0]  LINESTATE,
   input  logic [1:0]  VBUS_STATE,
   output logic [7:0]  FUN_CTRL,
   output logic [7:0]  OTG_CTRL,
   output logic        TX_ACTIVE,
   output logic        TX_CHIRP,
   output logic [7:0]  TX_BYTE,
   output logic        TX_BYTE_STRB,
   output logic [15:0] TX_COUNT
);

   typedef enum logic [3:0] {
      IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TURN1, RD_DATA, RD_TURN2,
      RX_TURN1, RX_DATA, RX_TURN2, TX
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  fun_q, fun_d;
   logic [7:0]  otg_q, otg_d;
   logic [7:0]  scr_q, scr_d;
   logic [3:0]  last_q, last_d;
   logic [3:0]  rxv_q, rxv_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_strb_q, tx_strb_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic        tx_first_q, tx_first_d;
   logic [7:0]  rd_data;
   logic [7:0]  fun_base;
   logic        rx_pend;

   always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
      if (RST_A_USB) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         fun_q      <= FUN_CTRL_RST;
         otg_q      <= OTG_CTRL_RST;
         scr_q      <= '0;
         last_q     <= '0;
         rxv_q      <= '0;
         tx_byte_q  <= '0;
         tx_strb_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         fun_q      <= fun_d;
         otg_q      <= otg_d;
         scr_q      <= scr_d;
         last_q     <= last_d;
         rxv_q      <= rxv_d;
         tx_byte_q  <= tx_byte_d;
         tx_strb_q  <= tx_strb_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_first_q <= tx_first_d;
      end
   end

   // Reads at base, base+1 and base+2 all return the base register.
   always_comb begin
      rd_data = 8'h00;
      case (addr_q)
         6'h04, 6'h05, 6'h06: rd_data = fun_q;
         6'h0A, 6'h0B, 6'h0C: rd_data = otg_q;
         6'h16, 6'h17, 6'h18: rd_data = scr_q;
         default:             rd_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      fun_base   = fun_q & 8'hDF;
      fun_d      = fun_base;
      otg_d      = otg_q;
      scr_d      = scr_q;
      last_d     = last_q;
      rxv_d      = rxv_q;
      tx_byte_d  = tx_byte_q;
      tx_strb_d  = 1'b0;
      tx_cnt_d   = tx_cnt_q;
      tx_first_d = 1'b0;
      rx_pend    = ({VBUS_STATE, LINESTATE} != last_q);

      case (state_q)
         IDLE: begin
            if (USB_DATA_I[7:6] != 2'b00) begin
               addr_d = USB_DATA_I[5:0];
               case (USB_DATA_I[7:6])
                  2'b01: begin
                     state_d    = TX;
                     tx_cnt_d   = '0;
                     tx_first_d = 1'b1;
                  end
                  2'b10:   state_d = WR_CMD;
                  default: state_d = RD_CMD;
               endcase
            end else if (rx_pend) begin
               rxv_d   = {VBUS_STATE, LINESTATE};
               state_d = RX_TURN1;
            end
         end
         WR_CMD:  state_d = WR_DATA;
         WR_DATA: begin
            wdata_d = USB_DATA_I;
            state_d = WR_STP;
         end
         WR_STP: begin
            // Without STP closing the write the data byte is dropped.
            if (USB_STP) begin
               case (addr_q)
                  6'h04:   fun_d = wdata_q;
                  6'h05:   fun_d = fun_base | wdata_q;
                  6'h06:   fun_d = fun_base & ~wdata_q;
                  6'h0A:   otg_d = wdata_q;
                  6'h0B:   otg_d = otg_q | wdata_q;
                  6'h0C:   otg_d = otg_q & ~wdata_q;
                  6'h16:   scr_d = wdata_q;
                  6'h17:   scr_d = scr_q | wdata_q;
                  6'h18:   scr_d = scr_q & ~wdata_q;
                  default: ;
               endcase
            end
            state_d = IDLE;
         end
         RD_CMD:   state_d = RD_TURN1;
         RD_TURN1: state_d = RD_DATA;
         RD_DATA:  state_d = RD_TURN2;
         RD_TURN2: state_d = IDLE;
         RX_TURN1: state_d = RX_DATA;
         RX_DATA: begin
            last_d  = rxv_q;
            state_d = RX_TURN2;
         end
         RX_TURN2: state_d = IDLE;
         TX: begin
            // The TXCMD cycle itself carries no payload byte.
            if (USB_STP) begin
               state_d = IDLE;
            end else if (!tx_first_q) begin
               tx_byte_d = USB_DATA_I;
               tx_strb_d = 1'b1;
               if (tx_cnt_q != 16'hFFFF) tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!USB_RESETN) begin
         state_d    = IDLE;
         addr_d     = '0;
         wdata_d    = '0;
         fun_d      = FUN_CTRL_RST;
         otg_d      = OTG_CTRL_RST;
         scr_d      = '0;
         last_d     = '0;
         rxv_d      = '0;
         tx_byte_d  = '0;
         tx_strb_d  = 1'b0;
         tx_cnt_d   = '0;
         tx_first_d = 1'b0;
      end
   end

   // Bus controls decode straight from the state so an async reset drops them at once.
   always_comb begin
      USB_DIR     = 1'b0;
      USB_NXT     = 1'b0;
      USB_DATA_OE = 1'b0;
      USB_DATA_O  = 8'h00;
      case (state_q)
         WR_CMD, WR_DATA, RD_CMD, TX: USB_NXT = 1'b1;
         RD_TURN1, RX_TURN1:          USB_DIR = 1'b1;
         RD_DATA: begin
            USB_DIR     = 1'b1;
            USB_DATA_OE = 1'b1;
            USB_DATA_O  = rd_data;
         end
         RX_DATA: begin
            USB_DIR     = 1'b1;
            USB_DATA_OE = 1'b1;
            USB_DATA_O  = {4'b0000, rxv_q};
         end
         default: ;
      endcase
   end

   assign FUN_CTRL     = fun_q;
   assign OTG_CTRL     = otg_q;
   assign TX_ACTIVE    = (state_q == TX);
   assign TX_CHIRP     = TX_ACTIVE && (fun_q[4:3] == 2'b10);
   assign TX_BYTE      = tx_byte_q;
   assign TX_BYTE_STRB = tx_strb_q;
   assign TX_COUNT     = tx_cnt_q;

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Directed bench for ulpi_phy_responder: register access, transmit/chirp, RX CMD and resets.
module tb_ulpi_phy_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        usb_resetn = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        stp = 1'b0;
   logic [1:0]  ls = 2'b00;
   logic [1:0]  vb = 2'b00;
   logic [7:0]  dout, fun, otg, tx_byte;
   logic        oe, dir, nxt, tx_active, tx_chirp, tx_strb;
   logic [15:0] tx_count;

   int checks = 0;
   int failures = 0;

   ulpi_phy_responder dut (
      .CLK_60M(clk), .RST_A_USB(rst), .USB_RESETN(usb_resetn),
      .USB_DATA_I(din), .USB_DATA_O(dout), .USB_DATA_OE(oe),
      .USB_DIR(dir), .USB_NXT(nxt), .USB_STP(stp),
      .LINESTATE(ls), .VBUS_STATE(vb), .FUN_CTRL(fun), .OTG_CTRL(otg),
      .TX_ACTIVE(tx_active), .TX_CHIRP(tx_chirp), .TX_BYTE(tx_byte),
      .TX_BYTE_STRB(tx_strb), .TX_COUNT(tx_count)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input logic with_stp);
      din = cmd;
      step;
      step;
      din = data;
      step;
      din = 8'h00;
      stp = with_stp;
      step;
      stp = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] cmd, output logic [7:0] d);
      din = cmd;
      step;
      din = 8'h00;
      step;
      step;
      d = dout;
      step;
      step;
   endtask

   task automatic test_reset;
      step;
      checks++;
      if ({dir, nxt, oe, tx_active, tx_strb} !== 5'b00000) begin
         failures++; $display("FAIL reset_ctrl: got %b expected 00000", {dir, nxt, oe, tx_active, tx_strb});
      end
      checks++;
      if ({dout, tx_byte, tx_count} !== 32'h0) begin
         failures++; $display("FAIL reset_data: got %h expected 00000000", {dout, tx_byte, tx_count});
      end
      checks++;
      if ({fun, otg} !== 16'h4106) begin
         failures++; $display("FAIL reset_regs: got %h expected 4106", {fun, otg});
      end
      rst = 1'b0;
      step;
   endtask

   task automatic test_read_reset;
      logic [7:0] d;
      din = 8'hC4;
      step;
      checks++;
      if ({dir, nxt, oe} !== 3'b010) begin
         failures++; $display("FAIL rd_n1: got %b expected 010", {dir, nxt, oe});
      end
      din = 8'h00;
      step;
      checks++;
      if ({dir, nxt, oe} !== 3'b100) begin
         failures++; $display("FAIL rd_n2: got %b expected 100", {dir, nxt, oe});
      end
      step;
      checks++;
      if ({dir, nxt, oe, dout} !== {3'b101, 8'h41}) begin
         failures++; $display("FAIL rd_n3: got %h expected %h", {dir, nxt, oe, dout}, {3'b101, 8'h41});
      end
      step;
      checks++;
      if ({dir, nxt, oe} !== 3'b000) begin
         failures++; $display("FAIL rd_n4: got %b expected 000", {dir, nxt, oe});
      end
      step;
      do_read(8'hCA, d);
      checks++;
      if (d !== 8'h06) begin
         failures++; $display("FAIL rd_otg: got %h expected 06", d);
      end
   endtask

   task automatic test_tx_short;
      din = 8'h41;
      step;
      checks++;
      if ({nxt, tx_active, tx_chirp, tx_count} !== {3'b110, 16'd0}) begin
         failures++; $display("FAIL tx_start: got %h expected %h", {nxt, tx_active, tx_chirp, tx_count}, {3'b110, 16'd0});
      end
      step;
      checks++;
      if (tx_strb !== 1'b0) begin
         failures++; $display("FAIL tx_cmd_byte: got %b expected 0", tx_strb);
      end
      din = 8'hA5;
      step;
      checks++;
      if ({tx_strb, tx_byte, tx_count} !== {1'b1, 8'hA5, 16'd1}) begin
         failures++; $display("FAIL tx_b0: got %h expected %h", {tx_strb, tx_byte, tx_count}, {1'b1, 8'hA5, 16'd1});
      end
      din = 8'h3C;
      step;
      stp = 1'b1;
      din = 8'hFF;
      step;
      stp = 1'b0;
      din = 8'h00;
      checks++;
      if ({nxt, tx_active, tx_strb, tx_byte, tx_count} !== {3'b000, 8'h3C, 16'd2}) begin
         failures++; $display("FAIL tx_end: got %h expected %h", {nxt, tx_active, tx_strb, tx_byte, tx_count}, {3'b000, 8'h3C, 16'd2});
      end
   endtask

   task automatic test_write;
      logic [7:0] d;
      do_write(8'h84, 8'h54, 1'b1);
      checks++;
      if (fun !== 8'h54) begin
         failures++; $display("FAIL wr_fun: got %h expected 54", fun);
      end
      do_read(8'hC4, d);
      checks++;
      if (d !== 8'h54) begin
         failures++; $display("FAIL rd_after_wr: got %h expected 54", d);
      end
   endtask

   task automatic test_set_clear;
      do_write(8'h85, 8'h20, 1'b1);
      checks++;
      if (fun !== 8'h74) begin
         failures++; $display("FAIL set_fun: got %h expected 74", fun);
      end
      step;
      checks++;
      if (fun !== 8'h54) begin
         failures++; $display("FAIL selfclear: got %h expected 54", fun);
      end
      do_write(8'h86, 8'h40, 1'b1);
      checks++;
      if (fun !== 8'h14) begin
         failures++; $display("FAIL clr_fun: got %h expected 14", fun);
      end
   endtask

   task automatic test_chirp;
      int strobes;
      int chirp_low;
      strobes = 0;
      chirp_low = 0;
      do_write(8'h84, 8'h54, 1'b1);
      din = 8'h40;
      step;
      checks++;
      if ({tx_chirp, tx_count} !== {1'b1, 16'd0}) begin
         failures++; $display("FAIL chirp_start: got %h expected %h", {tx_chirp, tx_count}, {1'b1, 16'd0});
      end
      din = 8'h00;
      step;
      for (int i = 0; i < 100; i++) begin
         step;
         if (tx_strb) strobes++;
         if (!tx_chirp) chirp_low++;
      end
      checks++;
      if (strobes !== 100 || chirp_low !== 0) begin
         failures++; $display("FAIL chirp_body: got strobes=%0d chirp_low=%0d expected 100 and 0", strobes, chirp_low);
      end
      stp = 1'b1;
      step;
      stp = 1'b0;
      checks++;
      if ({nxt, tx_active, tx_chirp, tx_count} !== {3'b000, 16'd100}) begin
         failures++; $display("FAIL chirp_end: got %h expected %h", {nxt, tx_active, tx_chirp, tx_count}, {3'b000, 16'd100});
      end
   endtask

   task automatic test_zero_len;
      din = 8'h40;
      step;
      din = 8'h00;
      stp = 1'b1;
      step;
      stp = 1'b0;
      checks++;
      if ({nxt, tx_active, tx_strb, tx_count} !== {3'b000, 16'd0}) begin
         failures++; $display("FAIL zero_len: got %h expected %h", {nxt, tx_active, tx_strb, tx_count}, {3'b000, 16'd0});
      end
   endtask

   task automatic test_rxcmd;
      ls = 2'b10;
      step;
      checks++;
      if ({dir, nxt, oe} !== 3'b100) begin
         failures++; $display("FAIL rx_m1: got %b expected 100", {dir, nxt, oe});
      end
      step;
      checks++;
      if ({dir, oe, dout} !== {2'b11, 8'h02}) begin
         failures++; $display("FAIL rx_m2: got %h expected %h", {dir, oe, dout}, {2'b11, 8'h02});
      end
      step;
      checks++;
      if ({dir, oe} !== 2'b00) begin
         failures++; $display("FAIL rx_m3: got %b expected 00", {dir, oe});
      end
      step;
      step;
      checks++;
      if (dir !== 1'b0) begin
         failures++; $display("FAIL rx_repeat: got %b expected 0", dir);
      end
   endtask

   task automatic test_rx_vs_write;
      ls = 2'b11;
      din = 8'h8A;
      step;
      checks++;
      if ({dir, nxt} !== 2'b01) begin
         failures++; $display("FAIL prio_n1: got %b expected 01", {dir, nxt});
      end
      step;
      din = 8'h5A;
      step;
      din = 8'h00;
      stp = 1'b1;
      step;
      stp = 1'b0;
      checks++;
      if ({dir, otg} !== {1'b0, 8'h5A}) begin
         failures++; $display("FAIL prio_wr: got %h expected %h", {dir, otg}, {1'b0, 8'h5A});
      end
      step;
      step;
      checks++;
      if ({dir, oe, dout} !== {2'b11, 8'h03}) begin
         failures++; $display("FAIL prio_rx: got %h expected %h", {dir, oe, dout}, {2'b11, 8'h03});
      end
      step;
      step;
   endtask

   task automatic test_scratch_unknown;
      logic [7:0] d;
      do_read(8'hEF, d);
      checks++;
      if (d !== 8'h00) begin
         failures++; $display("FAIL rd_2f: got %h expected 00", d);
      end
      do_write(8'h96, 8'hA5, 1'b1);
      do_read(8'hD8, d);
      checks++;
      if (d !== 8'hA5) begin
         failures++; $display("FAIL rd_scr_p2: got %h expected a5", d);
      end
   endtask

   task automatic test_usb_resetn;
      logic [7:0] d;
      usb_resetn = 1'b0;
      ls = 2'b00;
      step;
      usb_resetn = 1'b1;
      checks++;
      if ({fun, otg} !== 16'h4106) begin
         failures++; $display("FAIL resetn_regs: got %h expected 4106", {fun, otg});
      end
      do_read(8'hD6, d);
      checks++;
      if (d !== 8'h00) begin
         failures++; $display("FAIL resetn_scr: got %h expected 00", d);
      end
   endtask

   task automatic test_reset_midread;
      do_write(8'h84, 8'h54, 1'b1);
      din = 8'hC4;
      step;
      din = 8'h00;
      step;
      step;
      rst = 1'b1;
      #1;
      checks++;
      if ({dir, nxt, oe, fun} !== {3'b000, 8'h41}) begin
         failures++; $display("FAIL async_rst: got %h expected %h", {dir, nxt, oe, fun}, {3'b000, 8'h41});
      end
      step;
      rst = 1'b0;
      step;
      do_write(8'h84, 8'h99, 1'b0);
      step;
      checks++;
      if (fun !== 8'h41) begin
         failures++; $display("FAIL wr_no_stp: got %h expected 41", fun);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_read_reset;
      test_tx_short;
      test_write;
      test_set_clear;
      test_chirp;
      test_zero_len;
      test_rxcmd;
      test_rx_vs_write;
      test_scratch_unknown;
      test_usb_resetn;
      test_reset_midread;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
